cipher_core: RTL and testbench
==============================

# cipher_core

Keystroke-driven Vigenère cipher engine with character plotter. A 3-state controller selects key entry, encryption or decryption. The datapath transforms each incoming ASCII keystroke with a key of up to 4 letters. Each result is rendered as an 8×8 bit-pattern cell into a 320×240 pixel-write interface (x/y/colour/plot) that feeds the VGA adapter. It sits between the keyboard/ASCII front end and `vga_adapter`.

## Interface
- No parameters. Fixed values: key length 4, cell 8×8, screen 40×30 cells.
- `clk` in 1: system clock (50 MHz), all logic on rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `enter` in 1: raw active-low pushbutton level.
- `key_valid` in 1: one-cycle pulse; `key_char` is valid in that cycle.
- `key_char` in 8: ASCII code of the keystroke.
- `state` out 3: 0 = KEY_ENTRY, 1 = ENCRYPT, 2 = DECRYPT. Other codes are never produced.
- `cipher_idx` out 2: current key slot.
- `vga_char` out 8: last produced character.
- `x` out 9, `y` out 8, `colour` out 3, `plot` out 1: pixel write port.
- `busy` out 1: a cell is being drawn.

## Operation
- **Reset values.**
  - Outputs: `state`=0, `cipher_idx`=0, `vga_char`=0x00, `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0.
  - Internal: `key_len`=0, key[0..3]='A' (0x41), cursor (col,row)=(0,0).
- **Enter handling.**
  - `enter` passes through a 2-flop synchronizer; a press is its 1→0 transition.
  - Each press steps the state KEY_ENTRY→ENCRYPT→DECRYPT→KEY_ENTRY.
  - Every transition sets `cipher_idx`=0.
  - Entering KEY_ENTRY sets `key_len`=0.
  - Leaving KEY_ENTRY with `key_len`=0 sets `key_len`=1 and key[0]='A', which gives an identity cipher.
- **Letter normalisation.** 'a'..'z' (0x61–0x7A) map to uppercase. A "letter" is 'A'..'Z' after this mapping.
- **Keystroke acceptance.** A keystroke is accepted only when `key_valid`=1 and `busy`=0; otherwise it is dropped with no state change.
- **KEY_ENTRY.**
  - Letter with `key_len`<4: store it in key[`key_len`], increment `key_len`, set `vga_char`=letter, draw it.
  - Letter with `key_len`=4: ignored.
  - Non-letter: ignored.
  - `cipher_idx` = min(`key_len`, 3).
- **ENCRYPT.**
  - Letter p: `vga_char` = 'A' + ((p−'A') + (key[idx]−'A')) mod 26. Then `cipher_idx` = (idx+1) mod `key_len`.
  - Non-letter: passed through unchanged, drawn, idx unchanged.
- **DECRYPT.** Same as ENCRYPT with ((p−'A') − (key[idx]−'A') + 26) mod 26.
- **Arithmetic.** All cipher arithmetic uses 5-bit unsigned values in 0..25 with explicit mod-26 correction (one conditional subtract).
- **Drawing.**
  - Cell origin is (8·col, 8·row).
  - 64 pixels are written in row-major order: r=0..7 outer, c=0..7 inner.
  - `colour` = 3'b111 if 1≤r≤6 and `vga_char`[7−c]=1; otherwise 3'b000.
  - After the last pixel, col increments. At col 40, col returns to 0 and row increments. At row 30, row returns to 0.

## Timing
- **Keystroke to draw.**
  - Accepted keystroke at cycle N.
  - Cycle N+1: `vga_char`, key registers and `cipher_idx` update; `busy` rises.
  - Cycles N+2..N+65: `plot`=1 with one pixel per cycle.
  - Cycle N+66: `plot`=0, `busy`=0, cursor advanced.
- `x`/`y`/`colour` are registered and valid whenever `plot`=1.
- An enter press is recognised 2–3 cycles after the raw falling edge.
- **Simultaneous enter press and accepted keystroke.**
  - The keystroke is processed with the old state and old idx.
  - The state transition applies in the same cycle, and its idx reset to 0 wins.
  - A draw already started completes.
- **Reset mid-draw.** Immediately forces all reset values; the partial cell is abandoned.

## Test plan
- **Reset.** Assert `resetn`=0 mid-draw → all outputs 0 asynchronously. Release → `state`=0, `cipher_idx`=0.
- **Encrypt.** Key "LEMO"; enter; type "ATTACK" → `vga_char` sequence L,X,F,O,N,O. `cipher_idx` sequence 1,2,3,0,1,2.
- **Decrypt.** Same key; press enter twice from KEY_ENTRY (→DECRYPT); type "LXFONO" → A,T,T,A,C,K. Lowercase "lxfono" gives identical results.
- **Edge cases.**
  - Empty key then enter; type 'Q' → 'Q'.
  - Fifth key letter ignored: `key_len` stays 4, no draw.
  - Space (0x20) in ENCRYPT → 0x20 drawn, idx unchanged.
- **Glyph.** Draw 'A' (0x41) at cursor (0,0) → exactly 64 `plot` cycles.
  - White at (1,1)..(1,6) and (7,1)..(7,6); all other pixels black.
  - The next cell starts at x=8.
- **Wrap and busy.**
  - 40 accepted keystrokes → the 41st draws at x=0, y=8.
  - `key_valid` during `busy` is dropped: no `vga_char` change, no idx advance.

Source files
------------

// File: rtl/cipher_core_if.sv
// Keystroke input and pixel-write port of cipher_core.
// The core takes the slave side; the keyboard front end and VGA adapter take the master side.
interface cipher_core_if;
  logic       key_valid;
  logic [7:0] key_char;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    output key_valid, key_char,
    input  x, y, colour, plot, busy
  );

  modport slave (
    input  key_valid, key_char,
    output x, y, colour, plot, busy
  );
endinterface

// File: rtl/cipher_core.sv
// Vigenere cipher engine with a three-mode controller and an 8x8 cell plotter.
// Each accepted keystroke is transformed with a key of up to 4 letters and drawn into a 40x30 cell grid.
module cipher_core (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enter,
  cipher_core_if.slave bus,
  output logic [2:0]   state,
  output logic [1:0]   cipher_idx,
  output logic [7:0]   vga_char
);

  typedef enum logic [2:0] {
    KEY_ENTRY = 3'd0,
    ENCRYPT   = 3'd1,
    DECRYPT   = 3'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync_q;
  logic            press_s;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      key_len_q, key_len_d;
  logic [3:0][4:0] key_q, key_d;
  logic [7:0]      char_q, char_d;
  logic            busy_q, busy_d;
  logic [6:0]      pix_q, pix_d;
  logic [5:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic            plot_q, plot_d;
  logic [8:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [2:0]      colour_q, colour_d;

  logic            accept_s, start_s, is_letter_s;
  logic [7:0]      norm_s;
  logic [4:0]      p_s, k_s;
  logic [5:0]      sum_s, dif_s, enc_s, dec_s;
  logic [2:0]      idx_inc_s;

  // Enter synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], enter};
    end
  end

  assign press_s  = sync_q[2] & ~sync_q[1];
  assign accept_s = bus.key_valid & ~busy_q;

  // Letter normalisation and mod-26 cipher arithmetic on 0..25 letter indices.
  always_comb begin
    if ((bus.key_char >= 8'h61) && (bus.key_char <= 8'h7A)) begin
      norm_s = bus.key_char - 8'h20;
    end else begin
      norm_s = bus.key_char;
    end
    is_letter_s = (norm_s >= 8'h41) && (norm_s <= 8'h5A);
    // 'A'..'Z' carry 1..26 in their low five bits.
    p_s   = norm_s[4:0] - 5'd1;
    k_s   = key_q[idx_q];
    sum_s = {1'b0, p_s} + {1'b0, k_s};
    dif_s = {1'b0, p_s} + 6'd26 - {1'b0, k_s};
    if (sum_s >= 6'd26) begin
      enc_s = sum_s - 6'd26;
    end else begin
      enc_s = sum_s;
    end
    if (dif_s >= 6'd26) begin
      dec_s = dif_s - 6'd26;
    end else begin
      dec_s = dif_s;
    end
    idx_inc_s = {1'b0, idx_q} + 3'd1;
  end

  // Controller: keystroke processing with the current mode, then any enter-driven mode change.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_len_d = key_len_q;
    key_d     = key_q;
    char_d    = char_q;
    start_s   = 1'b0;
    if (accept_s) begin
      case (state_q)
        KEY_ENTRY: begin
          if (is_letter_s && (key_len_q < 3'd4)) begin
            key_d[key_len_q[1:0]] = p_s;
            key_len_d             = key_len_q + 3'd1;
            char_d                = norm_s;
            start_s               = 1'b1;
            idx_d                 = (key_len_d >= 3'd3) ? 2'd3 : key_len_d[1:0];
          end else begin
            start_s = 1'b0;
          end
        end
        ENCRYPT, DECRYPT: begin
          start_s = 1'b1;
          if (is_letter_s) begin
            char_d = 8'h41 + {2'b00, (state_q == ENCRYPT) ? enc_s : dec_s};
            idx_d  = (idx_inc_s >= key_len_q) ? 2'd0 : idx_inc_s[1:0];
          end else begin
            char_d = bus.key_char;
          end
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end
    if (press_s) begin
      idx_d = 2'd0;
      case (state_q)
        KEY_ENTRY: begin
          state_d = ENCRYPT;
          // An empty key becomes the single letter 'A', i.e. the identity cipher.
          if (key_len_d == 3'd0) begin
            key_len_d = 3'd1;
            key_d[0]  = 5'd0;
          end else begin
            key_len_d = key_len_d;
          end
        end
        ENCRYPT: begin
          state_d = DECRYPT;
        end
        DECRYPT: begin
          state_d   = KEY_ENTRY;
          key_len_d = 3'd0;
        end
        default: begin
          state_d   = KEY_ENTRY;
          key_len_d = 3'd0;
        end
      endcase
    end else begin
      state_d = state_d;
    end
  end

  // Plotter: 64 row-major pixels per cell, then the cursor advances.
  always_comb begin
    busy_d   = busy_q;
    pix_d    = pix_q;
    col_d    = col_q;
    row_d    = row_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (busy_q) begin
      if (!pix_q[6]) begin
        plot_d = 1'b1;
        x_d    = {col_q, pix_q[2:0]};
        y_d    = {row_q, pix_q[5:3]};
        if ((pix_q[5:3] >= 3'd1) && (pix_q[5:3] <= 3'd6) && char_q[3'd7 - pix_q[2:0]]) begin
          colour_d = 3'b111;
        end else begin
          colour_d = 3'b000;
        end
        pix_d = pix_q + 7'd1;
      end else begin
        busy_d = 1'b0;
        pix_d  = 7'd0;
        if (col_q == 6'd39) begin
          col_d = 6'd0;
          row_d = (row_q == 5'd29) ? 5'd0 : row_q + 5'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
    end else if (start_s) begin
      busy_d = 1'b1;
      pix_d  = 7'd0;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= KEY_ENTRY;
      idx_q     <= 2'd0;
      key_len_q <= 3'd0;
      key_q     <= {4{5'd0}};
      char_q    <= 8'h00;
      busy_q    <= 1'b0;
      pix_q     <= 7'd0;
      col_q     <= 6'd0;
      row_q     <= 5'd0;
      plot_q    <= 1'b0;
      x_q       <= 9'd0;
      y_q       <= 8'd0;
      colour_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_len_q <= key_len_d;
      key_q     <= key_d;
      char_q    <= char_d;
      busy_q    <= busy_d;
      pix_q     <= pix_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
    end
  end

  assign state      = state_q;
  assign cipher_idx = idx_q;
  assign vga_char   = char_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cipher_core.sv
// Directed bench for cipher_core: vector table for cipher results plus sequences for
// key entry, glyph rendering, busy drop, reset mid-draw and cursor wrap.
module tb_cipher_core;
  logic       clk = 1'b0;
  logic       resetn;
  logic       enter;
  logic [2:0] state;
  logic [1:0] cipher_idx;
  logic [7:0] vga_char;

  cipher_core_if bus_if ();

  cipher_core dut (
    .clk        (clk),
    .resetn     (resetn),
    .enter      (enter),
    .bus        (bus_if),
    .state      (state),
    .cipher_idx (cipher_idx),
    .vga_char   (vga_char)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] exp_ch;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs [19];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt, plot_cnt, glyph_err, first_x, first_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    bus_if.key_valid = 1'b1;
    bus_if.key_char  = c;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
  endtask

  // Follows a draw until busy drops, checking each pixel against the expected glyph.
  task automatic wait_draw(input logic [7:0] gc);
    int         guard;
    int         rx, ry;
    logic [2:0] ec;
    guard     = 0;
    busy_cnt  = 0;
    plot_cnt  = 0;
    glyph_err = 0;
    first_x   = -1;
    first_y   = -1;
    while (bus_if.busy && guard < 200) begin
      if (bus_if.plot) begin
        if (plot_cnt == 0) begin
          first_x = int'(bus_if.x);
          first_y = int'(bus_if.y);
        end
        rx = int'(bus_if.x[2:0]);
        ry = int'(bus_if.y[2:0]);
        ec = (ry >= 1 && ry <= 6 && gc[7 - rx]) ? 3'b111 : 3'b000;
        if (bus_if.colour !== ec) glyph_err++;
        plot_cnt++;
      end
      busy_cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic press_enter();
    @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic enter_key(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send(w[31 - 8*i -: 8]);
      check($sformatf("key%0d_char", i), 32'(vga_char), 32'(w[31 - 8*i -: 8]));
      check($sformatf("key%0d_idx", i), 32'(cipher_idx), (i >= 2) ? 32'd3 : 32'(i + 1));
      wait_draw(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic run_vec(input int i);
    send(vecs[i].ch);
    check($sformatf("vec%0d_char", i), 32'(vga_char), 32'(vecs[i].exp_ch));
    check($sformatf("vec%0d_idx", i), 32'(cipher_idx), 32'(vecs[i].exp_idx));
    check($sformatf("vec%0d_busy", i), 32'(bus_if.busy), 32'd1);
    wait_draw(vecs[i].exp_ch);
    check($sformatf("vec%0d_glyph", i), 32'(glyph_err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  32'(state),         32'd0);
    check({tag, "_idx"},    32'(cipher_idx),    32'd0);
    check({tag, "_char"},   32'(vga_char),      32'd0);
    check({tag, "_x"},      32'(bus_if.x),      32'd0);
    check({tag, "_y"},      32'(bus_if.y),      32'd0);
    check({tag, "_colour"}, 32'(bus_if.colour), 32'd0);
    check({tag, "_plot"},   32'(bus_if.plot),   32'd0);
    check({tag, "_busy"},   32'(bus_if.busy),   32'd0);
  endtask

  initial begin
    resetn           = 1'b0;
    enter            = 1'b1;
    bus_if.key_valid = 1'b0;
    bus_if.key_char  = 8'h00;

    // ENCRYPT with key LEMO: "ATTACK" then a space
    vecs[0]  = '{8'h41, 8'h4C, 2'd1};
    vecs[1]  = '{8'h54, 8'h58, 2'd2};
    vecs[2]  = '{8'h54, 8'h46, 2'd3};
    vecs[3]  = '{8'h41, 8'h4F, 2'd0};
    vecs[4]  = '{8'h43, 8'h4E, 2'd1};
    vecs[5]  = '{8'h4B, 8'h4F, 2'd2};
    vecs[6]  = '{8'h20, 8'h20, 2'd2};
    // DECRYPT "LXFONO"
    vecs[7]  = '{8'h4C, 8'h41, 2'd1};
    vecs[8]  = '{8'h58, 8'h54, 2'd2};
    vecs[9]  = '{8'h46, 8'h54, 2'd3};
    vecs[10] = '{8'h4F, 8'h41, 2'd0};
    vecs[11] = '{8'h4E, 8'h43, 2'd1};
    vecs[12] = '{8'h4F, 8'h4B, 2'd2};
    // DECRYPT "lxfono"
    vecs[13] = '{8'h6C, 8'h41, 2'd1};
    vecs[14] = '{8'h78, 8'h54, 2'd2};
    vecs[15] = '{8'h66, 8'h54, 2'd3};
    vecs[16] = '{8'h6F, 8'h41, 2'd0};
    vecs[17] = '{8'h6E, 8'h43, 2'd1};
    vecs[18] = '{8'h6F, 8'h4B, 2'd2};

    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Glyph 'A' drawn in KEY_ENTRY at cell (0,0), then 'B' in the next cell
    send(8'h41);
    check("glyph_char", 32'(vga_char), 32'h41);
    check("glyph_idx", 32'(cipher_idx), 32'd1);
    check("glyph_busy_rise", 32'(bus_if.busy), 32'd1);
    check("glyph_plot_first", 32'(bus_if.plot), 32'd0);
    wait_draw(8'h41);
    check("glyph_busy_cycles", 32'(busy_cnt), 32'd65);
    check("glyph_plot_cycles", 32'(plot_cnt), 32'd64);
    check("glyph_pixels", 32'(glyph_err), 32'd0);
    check("glyph_x0", 32'(first_x), 32'd0);
    check("glyph_y0", 32'(first_y), 32'd0);
    check("glyph_done_plot", 32'(bus_if.plot), 32'd0);
    send(8'h42);
    wait_draw(8'h42);
    check("next_cell_x", 32'(first_x), 32'd8);
    check("next_cell_y", 32'(first_y), 32'd0);

    // Key LEMO, fifth letter ignored, then ENCRYPT
    do_reset();
    enter_key("LEMO");
    send(8'h5A);
    check("fifth_busy", 32'(bus_if.busy), 32'd0);
    check("fifth_char", 32'(vga_char), 32'h4F);
    check("fifth_idx", 32'(cipher_idx), 32'd3);
    press_enter();
    check("enc_state", 32'(state), 32'd1);
    check("enc_idx0", 32'(cipher_idx), 32'd0);
    for (int i = 0; i <= 6; i++) run_vec(i);

    // Keystroke during busy is dropped
    send(8'h41);
    check("drop_first_char", 32'(vga_char), 32'h4D);
    check("drop_first_idx", 32'(cipher_idx), 32'd3);
    repeat (5) @(negedge clk);
    send(8'h42);
    check("drop_char", 32'(vga_char), 32'h4D);
    wait_draw(8'h4D);
    check("drop_idx_after", 32'(cipher_idx), 32'd3);
    check("drop_char_after", 32'(vga_char), 32'h4D);
    repeat (3) @(negedge clk);
    check("drop_no_redraw", 32'(bus_if.busy), 32'd0);

    // DECRYPT uppercase, then re-enter the key and DECRYPT lowercase
    press_enter();
    check("dec_state", 32'(state), 32'd2);
    check("dec_idx0", 32'(cipher_idx), 32'd0);
    for (int i = 7; i <= 12; i++) run_vec(i);
    press_enter();
    check("key_state", 32'(state), 32'd0);
    check("key_idx0", 32'(cipher_idx), 32'd0);
    enter_key("LEMO");
    press_enter();
    press_enter();
    check("dec2_state", 32'(state), 32'd2);
    for (int i = 13; i <= 18; i++) run_vec(i);

    // Empty key gives the identity cipher
    press_enter();
    press_enter();
    check("empty_state", 32'(state), 32'd1);
    send(8'h51);
    check("empty_char", 32'(vga_char), 32'h51);
    check("empty_idx", 32'(cipher_idx), 32'd0);
    wait_draw(8'h51);
    send(8'h71);
    check("empty_lower_char", 32'(vga_char), 32'h51);
    wait_draw(8'h51);

    // Reset in the middle of a draw
    send(8'h51);
    repeat (10) @(negedge clk);
    check("mid_plot", 32'(bus_if.plot), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rel_state", 32'(state), 32'd0);
    check("rel_idx", 32'(cipher_idx), 32'd0);
    check("rel_busy", 32'(bus_if.busy), 32'd0);

    // Cursor wraps to the next row after 40 cells
    press_enter();
    for (int k = 0; k < 40; k++) begin
      send(8'h20);
      wait_draw(8'h20);
      if (k == 39) begin
        check("wrap_last_x", 32'(first_x), 32'd312);
        check("wrap_last_y", 32'(first_y), 32'd0);
      end
    end
    send(8'h41);
    check("wrap_char", 32'(vga_char), 32'h41);
    wait_draw(8'h41);
    check("wrap_x", 32'(first_x), 32'd0);
    check("wrap_y", 32'(first_y), 32'd8);
    check("wrap_glyph", 32'(glyph_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
